vpifo_admission_scheduler: RTL and testbench

- Sits between the per-level client task queues and the RPU entry muxes of the virtualised SRAM PIFO tree.
- Each cycle it selects at most one push/pop per root RPU (root RPU = tree_id % LEVEL) using per-RPU round-robin over requesters.
- It enforces a minimum issue spacing per RPU and yields the slot to in-flight tree traffic.
- It tracks per-tree occupancy so that pushes to a full tree and pops from an empty tree are dropped and reported, never issued.

---
 rtl/vpifo_admission_scheduler_pkg.sv | 20 ++
 rtl/vpifo_admission_scheduler_if.sv | 39 +++
 rtl/vpifo_admission_scheduler_rr_arbiter.sv | 28 ++
 rtl/vpifo_admission_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_vpifo_admission_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vpifo_admission_scheduler_pkg.sv
// Shared types, constants and width helpers for the vPIFO admission scheduler.
package vpifo_sched_pkg;

    localparam logic DROP_FULL  = 1'b0;
    localparam logic DROP_EMPTY = 1'b1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        COOLDOWN = 1'b1
    } rpu_sched_state_t;

    function automatic int tree_num_bits(input int tree_num);
        return (tree_num > 1) ? $clog2(tree_num) : 1;
    endfunction

    function automatic int cnt_w(input int tree_cap);
        return $clog2(tree_cap + 1);
    endfunction

endpackage

// File: rtl/vpifo_admission_scheduler_if.sv
// Requester/RPU-side handshake bundle of the admission scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface vpifo_admission_scheduler_if #(
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4,
    parameter int DW       = 16
);
    import vpifo_sched_pkg::*;

    localparam int TNB = tree_num_bits(TREE_NUM);

    logic [LEVEL-1:0]           i_req_valid;
    logic [LEVEL-1:0]           i_req_push;
    logic [LEVEL-1:0][TNB-1:0]  i_req_tree_id;
    logic [LEVEL-1:0][DW-1:0]   i_req_data;
    logic [LEVEL-1:0]           o_req_ready;
    logic [LEVEL-1:0]           i_rpu_busy;
    logic [LEVEL-1:0]           o_rpu_push;
    logic [LEVEL-1:0]           o_rpu_pop;
    logic [LEVEL-1:0][TNB-1:0]  o_rpu_tree_id;
    logic [LEVEL-1:0][DW-1:0]   o_rpu_push_data;
    logic                       o_drop;
    logic                       o_drop_reason;
    logic [TNB-1:0]             o_drop_tree_id;
    logic [TREE_NUM-1:0]        o_tree_empty;

    modport slave (
        input  i_req_valid, i_req_push, i_req_tree_id, i_req_data, i_rpu_busy,
        output o_req_ready, o_rpu_push, o_rpu_pop, o_rpu_tree_id, o_rpu_push_data,
               o_drop, o_drop_reason, o_drop_tree_id, o_tree_empty
    );

    modport master (
        output i_req_valid, i_req_push, i_req_tree_id, i_req_data, i_rpu_busy,
        input  o_req_ready, o_rpu_push, o_rpu_pop, o_rpu_tree_id, o_rpu_push_data,
               o_drop, o_drop_reason, o_drop_tree_id, o_tree_empty
    );

endinterface

// File: rtl/vpifo_admission_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr_i and the first
// asserted request wins. Grant is one-hot or all zero.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    // Walk the requesters once, starting at the pointer, and stop at the first hit.
    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vpifo_admission_scheduler.sv
// Admission scheduler in front of the vPIFO RPU entry muxes: per-RPU
// round-robin over requesters, minimum issue spacing per RPU, and per-tree
// occupancy tracking that drops pushes to full and pops from empty trees.
//
// Per-RPU scheduler state:
//   state    | meaning
//   IDLE     | may grant when the RPU is not busy
//   COOLDOWN | counting down the issue gap, no grants
module vpifo_admission_scheduler
    import vpifo_sched_pkg::*;
#(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int LEVEL     = 4,
    parameter int TREE_NUM  = 4,
    parameter int TREE_CAP  = 1020,
    parameter int ISSUE_GAP = 2
)(
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    vpifo_admission_scheduler_if.slave bus
);

    localparam int DW  = MTW + PTW;
    localparam int TNB = tree_num_bits(TREE_NUM);
    localparam int CW  = cnt_w(TREE_CAP);
    localparam int PW  = (LEVEL > 1) ? $clog2(LEVEL) : 1;
    localparam int CDW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    localparam logic [CW-1:0]  CAP       = CW'(TREE_CAP);
    localparam logic [CDW-1:0] CD_LOAD   = CDW'(ISSUE_GAP - 1);
    localparam logic [0:0]     ST_IDLE     = IDLE;
    localparam logic [0:0]     ST_COOLDOWN = COOLDOWN;

    logic [LEVEL-1:0][PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [LEVEL-1:0][0:0]       state_q, state_d;
    logic [LEVEL-1:0][CDW-1:0]   cd_q, cd_d;
    logic [TREE_NUM-1:0][CW-1:0] cnt_q, cnt_d;

    logic [LEVEL-1:0]            push_q, push_d;
    logic [LEVEL-1:0]            pop_q, pop_d;
    logic [LEVEL-1:0][TNB-1:0]   tree_id_q, tree_id_d;
    logic [LEVEL-1:0][DW-1:0]    data_q, data_d;
    logic                        drop_q, drop_d;
    logic                        drop_reason_q, drop_reason_d;
    logic [TNB-1:0]              drop_tree_q, drop_tree_d;

    logic [LEVEL-1:0][LEVEL-1:0] cand;
    logic [LEVEL-1:0][LEVEL-1:0] gnt;
    logic [LEVEL-1:0]            gnt_any, is_push, is_drop, is_issue;
    logic [LEVEL-1:0][PW-1:0]    win;
    logic [LEVEL-1:0][TNB-1:0]   win_tree;

    function automatic logic [PW-1:0] rpu_of(input logic [TNB-1:0] tid);
        return PW'(int'(tid) % LEVEL);
    endfunction

    // Requester r competes for RPU k when it targets k and k is free to grant.
    always_comb begin
        cand = '0;
        for (int k = 0; k < LEVEL; k++) begin
            for (int r = 0; r < LEVEL; r++) begin
                cand[k][r] = bus.i_req_valid[r]
                          && (rpu_of(bus.i_req_tree_id[r]) == PW'(k))
                          && (state_q[k] == ST_IDLE)
                          && !bus.i_rpu_busy[k];
            end
        end
    end

    for (genvar k = 0; k < LEVEL; k++) begin : g_arb
        rr_arbiter #(.N(LEVEL)) u_arb (
            .req_i (cand[k]),
            .ptr_i (rr_ptr_q[k]),
            .gnt_o (gnt[k])
        );
    end

    // Decode each RPU's winner and decide between issue and drop.
    // Each requester targets exactly one RPU, so ready is never double-granted.
    always_comb begin
        bus.o_req_ready = '0;
        for (int k = 0; k < LEVEL; k++) begin
            gnt_any[k] = |gnt[k];
            win[k]     = '0;
            for (int r = 0; r < LEVEL; r++) begin
                if (gnt[k][r]) begin
                    win[k]             = PW'(r);
                    bus.o_req_ready[r] = 1'b1;
                end
            end
            win_tree[k] = bus.i_req_tree_id[win[k]];
            is_push[k]  = bus.i_req_push[win[k]];
            is_drop[k]  = gnt_any[k] && (is_push[k] ? (cnt_q[win_tree[k]] == CAP)
                                                    : (cnt_q[win_tree[k]] == '0));
            is_issue[k] = gnt_any[k] && !is_drop[k];
        end
    end

    // Round-robin pointers and cooldown FSM; drops do not start a cooldown.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        state_d  = state_q;
        cd_d     = cd_q;
        for (int k = 0; k < LEVEL; k++) begin
            if (gnt_any[k]) begin
                rr_ptr_d[k] = (win[k] == PW'(LEVEL - 1)) ? '0 : win[k] + PW'(1);
            end
            case (state_q[k])
                ST_IDLE: begin
                    if (is_issue[k]) begin
                        cd_d[k]    = CD_LOAD;
                        state_d[k] = (CD_LOAD != '0) ? ST_COOLDOWN : ST_IDLE;
                    end
                end
                default: begin
                    cd_d[k] = cd_q[k] - CDW'(1);
                    if (cd_q[k] == CDW'(1)) begin
                        state_d[k] = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Issue strobes, payload capture, drop report and occupancy update.
    // Trees never share an RPU, so each counter sees at most one update.
    always_comb begin
        push_d        = '0;
        pop_d         = '0;
        tree_id_d     = tree_id_q;
        data_d        = data_q;
        drop_d        = 1'b0;
        drop_reason_d = drop_reason_q;
        drop_tree_d   = drop_tree_q;
        cnt_d         = cnt_q;
        for (int k = 0; k < LEVEL; k++) begin
            if (is_issue[k]) begin
                push_d[k]    = is_push[k];
                pop_d[k]     = !is_push[k];
                tree_id_d[k] = win_tree[k];
                if (is_push[k]) begin
                    data_d[k]             = bus.i_req_data[win[k]];
                    cnt_d[win_tree[k]]    = cnt_q[win_tree[k]] + CW'(1);
                end else begin
                    cnt_d[win_tree[k]]    = cnt_q[win_tree[k]] - CW'(1);
                end
            end
        end
        for (int k = LEVEL - 1; k >= 0; k--) begin
            if (is_drop[k]) begin
                drop_d        = 1'b1;
                drop_reason_d = is_push[k] ? DROP_FULL : DROP_EMPTY;
                drop_tree_d   = win_tree[k];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            rr_ptr_q      <= '0;
            state_q       <= '0;
            cd_q          <= '0;
            cnt_q         <= '0;
            push_q        <= '0;
            pop_q         <= '0;
            tree_id_q     <= '0;
            data_q        <= '1;
            drop_q        <= 1'b0;
            drop_reason_q <= 1'b0;
            drop_tree_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
            cd_q          <= cd_d;
            cnt_q         <= cnt_d;
            push_q        <= push_d;
            pop_q         <= pop_d;
            tree_id_q     <= tree_id_d;
            data_q        <= data_d;
            drop_q        <= drop_d;
            drop_reason_q <= drop_reason_d;
            drop_tree_q   <= drop_tree_d;
        end
    end

    // Empty flags straight from the occupancy counters.
    always_comb begin
        for (int j = 0; j < TREE_NUM; j++) begin
            bus.o_tree_empty[j] = (cnt_q[j] == '0);
        end
    end

    assign bus.o_rpu_push      = push_q;
    assign bus.o_rpu_pop       = pop_q;
    assign bus.o_rpu_tree_id   = tree_id_q;
    assign bus.o_rpu_push_data = data_q;
    assign bus.o_drop          = drop_q;
    assign bus.o_drop_reason   = drop_reason_q;
    assign bus.o_drop_tree_id  = drop_tree_q;

endmodule

// File: tb/tb_vpifo_admission_scheduler.sv
// Bench for the vPIFO admission scheduler: a directed cycle table, a reset
// corner sequence and a randomized run against a queue-level reference model.
module tb_vpifo_admission_scheduler;
    import vpifo_sched_pkg::*;

    localparam int L    = 4;
    localparam int TN   = 4;
    localparam int DW   = 16;
    localparam int CAP  = 4;
    localparam int GAP  = 2;
    localparam int NRND = 1500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpifo_admission_scheduler_if #(.LEVEL(L), .TREE_NUM(TN), .DW(DW)) bus ();

    vpifo_admission_scheduler #(
        .PTW(16), .MTW(0), .LEVEL(L), .TREE_NUM(TN), .TREE_CAP(CAP), .ISSUE_GAP(GAP)
    ) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst_n;
        logic [L-1:0]  v, p, busy;
        logic [7:0]    t;
        logic [L-1:0]  er, epu, epo;
        logic          ed, ers;
        logic [1:0]    edt;
        logic [TN-1:0] ee;
        int            ck;
        logic [1:0]    ctid;
        logic [15:0]   cdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rs, input logic [3:0] v, input logic [3:0] p,
                                input logic [7:0] t, input logic [3:0] busy,
                                input logic [3:0] er, input logic [3:0] epu, input logic [3:0] epo,
                                input logic ed, input logic ers, input logic [1:0] edt,
                                input logic [3:0] ee, input int ck = -1,
                                input logic [1:0] ctid = 2'd0, input logic [15:0] cdata = 16'h0);
        vec_t x;
        x.rst_n = rs; x.v = v; x.p = p; x.t = t; x.busy = busy;
        x.er = er; x.epu = epu; x.epo = epo; x.ed = ed; x.ers = ers; x.edt = edt;
        x.ee = ee; x.ck = ck; x.ctid = ctid; x.cdata = cdata;
        vecs.push_back(x);
    endfunction

    function automatic logic [15:0] fixed_data(input int r);
        return 16'h00AA + 16'(r * 16'h1100);
    endfunction

    // Reference model state for the randomized run.
    logic [L-1:0] mv, mp, mbusy;
    int           mt[L];
    logic [15:0]  md[L];
    int           mptr[L];
    int           mlast[L];
    int           mcnt[TN];
    int           cyc;

    function automatic void new_req(input int r);
        mv[r] = ($urandom_range(0, 9) < 7);
        mp[r] = ($urandom_range(0, 9) < 6);
        mt[r] = int'($urandom_range(0, TN - 1));
        md[r] = 16'($urandom);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // rst v     p     t            busy  er    epu   epo   ed ers edt   ee
        add(0, 4'b0000, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1111);
        add(1, 4'b0001, 4'b0001, 8'b00_00_00_01, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 0, 0, 2'd0, 4'b1101, 1, 2'd1, 16'h00AA);
        add(1, 4'b0000, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1101);
        add(1, 4'b0001, 4'b0000, 8'b00_00_00_11, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 1, 2'd3, 4'b1101);
        add(1, 4'b1101, 4'b1101, 8'b10_10_10_10, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b1101, 4'b1101, 8'b10_10_10_10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b1101, 4'b1101, 8'b10_10_10_10, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b1101, 4'b1101, 8'b10_10_10_10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b1101, 4'b1101, 8'b10_10_10_10, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b1101, 4'b1101, 8'b10_10_10_10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b0000, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1001);
        // fill tree 0 to capacity through requester 1
        for (int i = 0; i < 4; i++) begin
            add(1, 4'b0010, 4'b0010, 8'b00_00_00_00, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 0, 0, 2'd0, 4'b1000);
            add(1, 4'b0010, 4'b0010, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1000);
        end
        add(1, 4'b0010, 4'b0010, 8'b00_00_00_00, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b1000);
        // drain: exactly four pops are legal, the fifth is dropped
        for (int i = 0; i < 4; i++) begin
            add(1, 4'b0010, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 0, 0, 2'd0,
                (i == 3) ? 4'b1001 : 4'b1000);
            if (i < 3)
                add(1, 4'b0010, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1000);
        end
        add(1, 4'b0010, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b0010, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 1, 2'd0, 4'b1001);
        // RPU1 busy for three cycles
        for (int i = 0; i < 3; i++)
            add(1, 4'b0010, 4'b0010, 8'b00_00_01_00, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1001);
        add(1, 4'b0010, 4'b0010, 8'b00_00_01_00, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 0, 0, 2'd0, 4'b1001, 1, 2'd1, 16'h11AA);
        add(1, 4'b0000, 4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b1001);
        // two drops in one cycle: RPU0 (tree 0) is reported over RPU3 (tree 3)
        add(1, 4'b0101, 4'b0000, 8'b00_00_00_11, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1, 1, 2'd0, 4'b1001);
        // simultaneous legal issues on two RPUs
        add(1, 4'b1001, 4'b0001, 8'b10_00_00_01, 4'b0000, 4'b1001, 4'b0010, 4'b0100, 0, 0, 2'd0, 4'b1001, 1, 2'd1, 16'h00AA);

        bus.i_req_valid   = '0;
        bus.i_req_push    = '0;
        bus.i_req_tree_id = '0;
        bus.i_rpu_busy    = '0;
        for (int r = 0; r < L; r++) bus.i_req_data[r] = fixed_data(r);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t x;
            x = vecs[i];
            rst_n             = x.rst_n;
            bus.i_req_valid   = x.v;
            bus.i_req_push    = x.p;
            bus.i_req_tree_id = x.t;
            bus.i_rpu_busy    = x.busy;
            @(negedge clk);
            chk($sformatf("row%0d ready", i), 64'(bus.o_req_ready), 64'(x.er));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d rpu_push", i), 64'(bus.o_rpu_push), 64'(x.epu));
            chk($sformatf("row%0d rpu_pop", i), 64'(bus.o_rpu_pop), 64'(x.epo));
            chk($sformatf("row%0d drop", i), 64'(bus.o_drop), 64'(x.ed));
            if (x.ed) begin
                chk($sformatf("row%0d drop_reason", i), 64'(bus.o_drop_reason), 64'(x.ers));
                chk($sformatf("row%0d drop_tree", i), 64'(bus.o_drop_tree_id), 64'(x.edt));
            end
            chk($sformatf("row%0d tree_empty", i), 64'(bus.o_tree_empty), 64'(x.ee));
            if (x.ck >= 0) begin
                chk($sformatf("row%0d rpu_tree_id", i), 64'(bus.o_rpu_tree_id[x.ck]), 64'(x.ctid));
                chk($sformatf("row%0d rpu_data", i), 64'(bus.o_rpu_push_data[x.ck]), 64'(x.cdata));
            end
        end

        // Reset lands on the handshake edge: the pending issue and all occupancy vanish.
        bus.i_req_valid   = 4'b0001;
        bus.i_req_push    = 4'b0001;
        bus.i_req_tree_id = 8'b00_00_00_11;
        @(negedge clk);
        chk("rst ready before reset", 64'(bus.o_req_ready), 64'(4'b0001));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst no push strobe", 64'(bus.o_rpu_push), 64'(0));
        chk("rst no drop", 64'(bus.o_drop), 64'(0));
        chk("rst tree_empty", 64'(bus.o_tree_empty), 64'(4'b1111));
        chk("rst push_data ones", 64'(bus.o_rpu_push_data), 64'({L{16'hFFFF}}));
        bus.i_req_valid = '0;
        @(posedge clk);
        #1;

        // Randomized run against the reference model.
        for (int k = 0; k < L; k++) begin
            mptr[k]  = 0;
            mlast[k] = -100;
        end
        for (int j = 0; j < TN; j++) mcnt[j] = 0;
        for (int r = 0; r < L; r++) new_req(r);
        cyc   = 0;
        rst_n = 1'b1;

        for (int n = 0; n < NRND; n++) begin
            logic [L-1:0]  er, epu, epo;
            logic          ed, ers;
            logic [1:0]    edt;
            logic [1:0]    etid[L];
            logic [15:0]   edata[L];
            logic [TN-1:0] ee;

            for (int k = 0; k < L; k++) mbusy[k] = ($urandom_range(0, 4) == 0);
            bus.i_req_valid = mv;
            bus.i_req_push  = mp;
            bus.i_rpu_busy  = mbusy;
            for (int r = 0; r < L; r++) begin
                bus.i_req_tree_id[r] = 2'(mt[r]);
                bus.i_req_data[r]    = md[r];
            end

            er = '0; epu = '0; epo = '0; ed = 1'b0; ers = 1'b0; edt = '0;
            for (int k = 0; k < L; k++) begin
                etid[k]  = '0;
                edata[k] = '0;
                if (!mbusy[k] && (cyc - mlast[k] >= GAP)) begin
                    int w;
                    w = -1;
                    for (int i = 0; i < L; i++) begin
                        int r;
                        r = (mptr[k] + i) % L;
                        if (w < 0 && mv[r] && (mt[r] % L == k)) w = r;
                    end
                    if (w >= 0) begin
                        er[w]   = 1'b1;
                        mptr[k] = (w + 1) % L;
                        if (mp[w] ? (mcnt[mt[w]] == CAP) : (mcnt[mt[w]] == 0)) begin
                            if (!ed) begin
                                ed  = 1'b1;
                                ers = !mp[w];
                                edt = 2'(mt[w]);
                            end
                        end else begin
                            mlast[k] = cyc;
                            etid[k]  = 2'(mt[w]);
                            if (mp[w]) begin
                                epu[k]   = 1'b1;
                                edata[k] = md[w];
                                mcnt[mt[w]]++;
                            end else begin
                                epo[k] = 1'b1;
                                mcnt[mt[w]]--;
                            end
                        end
                    end
                end
            end
            for (int j = 0; j < TN; j++) ee[j] = (mcnt[j] == 0);

            @(negedge clk);
            chk($sformatf("rnd%0d ready", n), 64'(bus.o_req_ready), 64'(er));
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d rpu_push", n), 64'(bus.o_rpu_push), 64'(epu));
            chk($sformatf("rnd%0d rpu_pop", n), 64'(bus.o_rpu_pop), 64'(epo));
            chk($sformatf("rnd%0d drop", n), 64'(bus.o_drop), 64'(ed));
            if (ed) begin
                chk($sformatf("rnd%0d drop_reason", n), 64'(bus.o_drop_reason), 64'(ers));
                chk($sformatf("rnd%0d drop_tree", n), 64'(bus.o_drop_tree_id), 64'(edt));
            end
            chk($sformatf("rnd%0d tree_empty", n), 64'(bus.o_tree_empty), 64'(ee));
            for (int k = 0; k < L; k++) begin
                if (epu[k] || epo[k])
                    chk($sformatf("rnd%0d rpu%0d tree_id", n, k), 64'(bus.o_rpu_tree_id[k]), 64'(etid[k]));
                if (epu[k])
                    chk($sformatf("rnd%0d rpu%0d data", n, k), 64'(bus.o_rpu_push_data[k]), 64'(edata[k]));
            end

            for (int r = 0; r < L; r++) begin
                if (er[r] || !mv[r]) new_req(r);
            end
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
